// File: rtl/rename_unit.sv
// Two-wide register rename core: RAT, RRAT, PRF with ready bits, and free list.
// Optional same-cycle CDB-to-read forwarding is enabled by defining CDB_BYPASS_EN.
module rename_unit #(
  parameter int unsigned ARF_SIZE = 32,
  parameter int unsigned PRF_SIZE = 64,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [$clog2(ARF_SIZE)-1:0] inst1_opa_arf,
  input  logic [$clog2(ARF_SIZE)-1:0] inst1_opb_arf,
  input  logic [$clog2(ARF_SIZE)-1:0] inst1_dest_arf,
  input  logic                        inst1_dest_rename,
  input  logic [$clog2(ARF_SIZE)-1:0] inst2_opa_arf,
  input  logic [$clog2(ARF_SIZE)-1:0] inst2_opb_arf,
  input  logic [$clog2(ARF_SIZE)-1:0] inst2_dest_arf,
  input  logic                        inst2_dest_rename,
  output logic [$clog2(PRF_SIZE)-1:0] inst1_opa_prf,
  output logic [$clog2(PRF_SIZE)-1:0] inst1_opb_prf,
  output logic                        inst1_opa_ready,
  output logic                        inst1_opb_ready,
  output logic [DATA_W-1:0]           inst1_opa_value,
  output logic [DATA_W-1:0]           inst1_opb_value,
  output logic [$clog2(PRF_SIZE)-1:0] inst1_dest_prf,
  output logic [$clog2(PRF_SIZE)-1:0] inst1_old_dest_prf,
  output logic [$clog2(PRF_SIZE)-1:0] inst2_opa_prf,
  output logic [$clog2(PRF_SIZE)-1:0] inst2_opb_prf,
  output logic                        inst2_opa_ready,
  output logic                        inst2_opb_ready,
  output logic [DATA_W-1:0]           inst2_opa_value,
  output logic [DATA_W-1:0]           inst2_opb_value,
  output logic [$clog2(PRF_SIZE)-1:0] inst2_dest_prf,
  output logic [$clog2(PRF_SIZE)-1:0] inst2_old_dest_prf,
  output logic                        rename_halt,
  output logic                        prf_is_full,
  input  logic                        cdb1_valid,
  input  logic [$clog2(PRF_SIZE)-1:0] cdb1_tag,
  input  logic [DATA_W-1:0]           cdb1_value,
  input  logic                        cdb2_valid,
  input  logic [$clog2(PRF_SIZE)-1:0] cdb2_tag,
  input  logic [DATA_W-1:0]           cdb2_value,
  input  logic                        retire1_valid,
  input  logic [$clog2(ARF_SIZE)-1:0] retire1_arf,
  input  logic [$clog2(PRF_SIZE)-1:0] retire1_prf,
  output logic [DATA_W-1:0]           retire1_value,
  input  logic                        retire2_valid,
  input  logic [$clog2(ARF_SIZE)-1:0] retire2_arf,
  input  logic [$clog2(PRF_SIZE)-1:0] retire2_prf,
  output logic [DATA_W-1:0]           retire2_value,
  input  logic                        mispredict
);
  localparam int unsigned PW  = $clog2(PRF_SIZE);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned NRD = 6;
  localparam logic [PRF_SIZE-1:0] ARF_MASK = {{(PRF_SIZE-ARF_SIZE){1'b0}}, {ARF_SIZE{1'b1}}};

  logic [PW-1:0]     r_rat  [ARF_SIZE];
  logic [PW-1:0]     r_rrat [ARF_SIZE];
  logic [DATA_W-1:0] r_val  [PRF_SIZE];
  logic [PRF_SIZE-1:0] r_rdy, r_free;

  logic [PW-1:0]     w_rat_nxt  [ARF_SIZE];
  logic [PW-1:0]     w_rrat_nxt [ARF_SIZE];
  logic [DATA_W-1:0] w_val_nxt  [PRF_SIZE];
  logic [PRF_SIZE-1:0] w_rdy_nxt, w_free_nxt, w_ret_free;

  logic [PW-1:0] w_tag_a, w_tag_b, w_tag1, w_tag2;
  logic          w_vld_a, w_vld_b;
  logic [CW-1:0] w_free_cnt, w_req;
  logic          w_halt, w_do_ren, w_alloc1, w_alloc2, w_fwd_2a, w_fwd_2b;

  logic [PW-1:0]     w_rd_tag [NRD];
  logic [NRD-1:0]    w_rd_rdy;
  logic [DATA_W-1:0] w_rd_val [NRD];

  // Lowest and next-lowest free entries plus the free count.
  always_comb begin
    w_tag_a    = '0;
    w_tag_b    = '0;
    w_vld_a    = 1'b0;
    w_vld_b    = 1'b0;
    w_free_cnt = '0;
    for (int i = 0; i < PRF_SIZE; i++) begin
      if (r_free[i]) begin
        w_free_cnt = w_free_cnt + CW'(1);
        if (!w_vld_a) begin
          w_tag_a = PW'(i);
          w_vld_a = 1'b1;
        end else if (!w_vld_b) begin
          w_tag_b = PW'(i);
          w_vld_b = 1'b1;
        end
      end
    end
  end

  assign w_req    = CW'(inst1_dest_rename) + CW'(inst2_dest_rename);
  assign w_halt   = !mispredict && (w_req > w_free_cnt);
  assign w_do_ren = !mispredict && !w_halt;
  assign w_alloc1 = w_do_ren && inst1_dest_rename;
  assign w_alloc2 = w_do_ren && inst2_dest_rename;
  assign w_tag1   = w_alloc1 ? w_tag_a : '0;
  assign w_tag2   = !w_alloc2 ? '0 : (inst1_dest_rename ? w_tag_b : w_tag_a);

  assign rename_halt    = w_halt;
  assign prf_is_full    = (w_free_cnt == '0);
  assign inst1_dest_prf = w_tag1;
  assign inst2_dest_prf = w_tag2;

  assign w_rd_tag[0] = r_rat[inst1_opa_arf];
  assign w_rd_tag[1] = r_rat[inst1_opb_arf];
  assign w_rd_tag[2] = r_rat[inst2_opa_arf];
  assign w_rd_tag[3] = r_rat[inst2_opb_arf];
  assign w_rd_tag[4] = retire1_prf;
  assign w_rd_tag[5] = retire2_prf;

  // PRF read ports; cdb2 overrides cdb1 when forwarding is enabled.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_rd_rdy[k] = r_rdy[w_rd_tag[k]];
      w_rd_val[k] = r_val[w_rd_tag[k]];
`ifdef CDB_BYPASS_EN
      if (cdb1_valid && (cdb1_tag == w_rd_tag[k])) begin
        w_rd_rdy[k] = 1'b1;
        w_rd_val[k] = cdb1_value;
      end
      if (cdb2_valid && (cdb2_tag == w_rd_tag[k])) begin
        w_rd_rdy[k] = 1'b1;
        w_rd_val[k] = cdb2_value;
      end
`endif
    end
  end

  assign w_fwd_2a = inst1_dest_rename && (inst2_opa_arf == inst1_dest_arf);
  assign w_fwd_2b = inst1_dest_rename && (inst2_opb_arf == inst1_dest_arf);

  assign inst1_opa_prf   = w_rd_tag[0];
  assign inst1_opa_ready = w_rd_rdy[0];
  assign inst1_opa_value = w_rd_rdy[0] ? w_rd_val[0] : '0;
  assign inst1_opb_prf   = w_rd_tag[1];
  assign inst1_opb_ready = w_rd_rdy[1];
  assign inst1_opb_value = w_rd_rdy[1] ? w_rd_val[1] : '0;
  assign inst2_opa_prf   = w_fwd_2a ? w_tag1 : w_rd_tag[2];
  assign inst2_opa_ready = !w_fwd_2a && w_rd_rdy[2];
  assign inst2_opa_value = inst2_opa_ready ? w_rd_val[2] : '0;
  assign inst2_opb_prf   = w_fwd_2b ? w_tag1 : w_rd_tag[3];
  assign inst2_opb_ready = !w_fwd_2b && w_rd_rdy[3];
  assign inst2_opb_value = inst2_opb_ready ? w_rd_val[3] : '0;

  assign inst1_old_dest_prf = r_rat[inst1_dest_arf];
  assign inst2_old_dest_prf = (inst1_dest_rename && (inst2_dest_arf == inst1_dest_arf)) ?
                              w_tag1 : r_rat[inst2_dest_arf];
  assign retire1_value = w_rd_val[4];
  assign retire2_value = w_rd_val[5];

  // Retirement in order: retire2 sees the RRAT already updated by retire1.
  always_comb begin
    w_rrat_nxt = r_rrat;
    w_ret_free = '0;
    if (retire1_valid) begin
      w_ret_free[r_rrat[retire1_arf]] = 1'b1;
      w_rrat_nxt[retire1_arf]         = retire1_prf;
    end
    if (retire2_valid) begin
      w_ret_free[w_rrat_nxt[retire2_arf]] = 1'b1;
      w_rrat_nxt[retire2_arf]             = retire2_prf;
    end
  end

  // Speculative map and free list; mispredict rebuilds both from the post-retire RRAT.
  always_comb begin
    w_rat_nxt  = r_rat;
    w_free_nxt = r_free | w_ret_free;
    if (w_alloc1) w_free_nxt[w_tag1] = 1'b0;
    if (w_alloc2) w_free_nxt[w_tag2] = 1'b0;
    if (mispredict) begin
      w_rat_nxt  = w_rrat_nxt;
      w_free_nxt = '1;
      for (int i = 0; i < ARF_SIZE; i++) w_free_nxt[w_rrat_nxt[i]] = 1'b0;
    end else begin
      if (w_alloc1) w_rat_nxt[inst1_dest_arf] = w_tag1;
      if (w_alloc2) w_rat_nxt[inst2_dest_arf] = w_tag2;
    end
  end

  always_comb begin
    w_rdy_nxt = r_rdy;
    w_val_nxt = r_val;
    if (w_alloc1) w_rdy_nxt[w_tag1] = 1'b0;
    if (w_alloc2) w_rdy_nxt[w_tag2] = 1'b0;
    if (cdb1_valid) begin
      w_val_nxt[cdb1_tag] = cdb1_value;
      w_rdy_nxt[cdb1_tag] = 1'b1;
    end
    if (cdb2_valid) begin
      w_val_nxt[cdb2_tag] = cdb2_value;
      w_rdy_nxt[cdb2_tag] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARF_SIZE; i++) begin
        r_rat[i]  <= PW'(i);
        r_rrat[i] <= PW'(i);
      end
      for (int i = 0; i < PRF_SIZE; i++) r_val[i] <= '0;
      r_rdy  <= ARF_MASK;
      r_free <= ~ARF_MASK;
    end else begin
      r_rat  <= w_rat_nxt;
      r_rrat <= w_rrat_nxt;
      r_val  <= w_val_nxt;
      r_rdy  <= w_rdy_nxt;
      r_free <= w_free_nxt;
    end
  end
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit: a cycle-by-cycle vector table plus hand-written
// sequences for free-list exhaustion, mispredict recovery and mid-run reset.
module tb_rename_unit;
  logic clock = 1'b0;
  logic reset;
  logic [4:0] inst1_opa_arf, inst1_opb_arf, inst1_dest_arf;
  logic [4:0] inst2_opa_arf, inst2_opb_arf, inst2_dest_arf;
  logic inst1_dest_rename, inst2_dest_rename;
  logic [5:0] inst1_opa_prf, inst1_opb_prf, inst1_dest_prf, inst1_old_dest_prf;
  logic [5:0] inst2_opa_prf, inst2_opb_prf, inst2_dest_prf, inst2_old_dest_prf;
  logic inst1_opa_ready, inst1_opb_ready, inst2_opa_ready, inst2_opb_ready;
  logic [63:0] inst1_opa_value, inst1_opb_value, inst2_opa_value, inst2_opb_value;
  logic rename_halt, prf_is_full;
  logic cdb1_valid, cdb2_valid;
  logic [5:0] cdb1_tag, cdb2_tag;
  logic [63:0] cdb1_value, cdb2_value;
  logic retire1_valid, retire2_valid;
  logic [4:0] retire1_arf, retire2_arf;
  logic [5:0] retire1_prf, retire2_prf;
  logic [63:0] retire1_value, retire2_value;
  logic mispredict;

  always #5 clock = ~clock;

  rename_unit dut (
    .clock(clock), .reset(reset),
    .inst1_opa_arf(inst1_opa_arf), .inst1_opb_arf(inst1_opb_arf),
    .inst1_dest_arf(inst1_dest_arf), .inst1_dest_rename(inst1_dest_rename),
    .inst2_opa_arf(inst2_opa_arf), .inst2_opb_arf(inst2_opb_arf),
    .inst2_dest_arf(inst2_dest_arf), .inst2_dest_rename(inst2_dest_rename),
    .inst1_opa_prf(inst1_opa_prf), .inst1_opb_prf(inst1_opb_prf),
    .inst1_opa_ready(inst1_opa_ready), .inst1_opb_ready(inst1_opb_ready),
    .inst1_opa_value(inst1_opa_value), .inst1_opb_value(inst1_opb_value),
    .inst1_dest_prf(inst1_dest_prf), .inst1_old_dest_prf(inst1_old_dest_prf),
    .inst2_opa_prf(inst2_opa_prf), .inst2_opb_prf(inst2_opb_prf),
    .inst2_opa_ready(inst2_opa_ready), .inst2_opb_ready(inst2_opb_ready),
    .inst2_opa_value(inst2_opa_value), .inst2_opb_value(inst2_opb_value),
    .inst2_dest_prf(inst2_dest_prf), .inst2_old_dest_prf(inst2_old_dest_prf),
    .rename_halt(rename_halt), .prf_is_full(prf_is_full),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
    .retire1_valid(retire1_valid), .retire1_arf(retire1_arf), .retire1_prf(retire1_prf),
    .retire1_value(retire1_value),
    .retire2_valid(retire2_valid), .retire2_arf(retire2_arf), .retire2_prf(retire2_prf),
    .retire2_value(retire2_value),
    .mispredict(mispredict)
  );

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] i1_opa, i1_opb, i1_dest; logic i1_ren;
    logic [4:0] i2_opa, i2_opb, i2_dest; logic i2_ren;
    logic c1_v; logic [5:0] c1_tag; logic [63:0] c1_val;
    logic c2_v; logic [5:0] c2_tag; logic [63:0] c2_val;
    logic r1_v; logic [4:0] r1_arf; logic [5:0] r1_prf;
    logic r2_v; logic [4:0] r2_arf; logic [5:0] r2_prf;
    logic misp;
  } in_t;

  typedef struct packed {
    logic [5:0] a1_prf; logic a1_rdy; logic [63:0] a1_val;
    logic [5:0] b1_prf; logic b1_rdy;
    logic [5:0] a2_prf; logic a2_rdy; logic [63:0] a2_val;
    logic [5:0] b2_prf;
    logic [5:0] d1, d2, o1, o2;
    logic halt, full;
    logic [63:0] rv1;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic apply(input in_t v);
    inst1_opa_arf = v.i1_opa; inst1_opb_arf = v.i1_opb;
    inst1_dest_arf = v.i1_dest; inst1_dest_rename = v.i1_ren;
    inst2_opa_arf = v.i2_opa; inst2_opb_arf = v.i2_opb;
    inst2_dest_arf = v.i2_dest; inst2_dest_rename = v.i2_ren;
    cdb1_valid = v.c1_v; cdb1_tag = v.c1_tag; cdb1_value = v.c1_val;
    cdb2_valid = v.c2_v; cdb2_tag = v.c2_tag; cdb2_value = v.c2_val;
    retire1_valid = v.r1_v; retire1_arf = v.r1_arf; retire1_prf = v.r1_prf;
    retire2_valid = v.r2_v; retire2_arf = v.r2_arf; retire2_prf = v.r2_prf;
    mispredict = v.misp;
  endtask

  task automatic check_vec(input int n, input exp_t e);
    chk($sformatf("v%0d.opa1_prf", n), 64'(inst1_opa_prf), 64'(e.a1_prf));
    chk($sformatf("v%0d.opa1_rdy", n), 64'(inst1_opa_ready), 64'(e.a1_rdy));
    chk($sformatf("v%0d.opa1_val", n), inst1_opa_value, e.a1_val);
    chk($sformatf("v%0d.opb1_prf", n), 64'(inst1_opb_prf), 64'(e.b1_prf));
    chk($sformatf("v%0d.opb1_rdy", n), 64'(inst1_opb_ready), 64'(e.b1_rdy));
    chk($sformatf("v%0d.opa2_prf", n), 64'(inst2_opa_prf), 64'(e.a2_prf));
    chk($sformatf("v%0d.opa2_rdy", n), 64'(inst2_opa_ready), 64'(e.a2_rdy));
    chk($sformatf("v%0d.opa2_val", n), inst2_opa_value, e.a2_val);
    chk($sformatf("v%0d.opb2_prf", n), 64'(inst2_opb_prf), 64'(e.b2_prf));
    chk($sformatf("v%0d.dest1", n), 64'(inst1_dest_prf), 64'(e.d1));
    chk($sformatf("v%0d.dest2", n), 64'(inst2_dest_prf), 64'(e.d2));
    chk($sformatf("v%0d.old1", n), 64'(inst1_old_dest_prf), 64'(e.o1));
    chk($sformatf("v%0d.old2", n), 64'(inst2_old_dest_prf), 64'(e.o2));
    chk($sformatf("v%0d.halt", n), 64'(rename_halt), 64'(e.halt));
    chk($sformatf("v%0d.full", n), 64'(prf_is_full), 64'(e.full));
    chk($sformatf("v%0d.ret1_val", n), retire1_value, e.rv1);
  endtask

  localparam int NV = 10;
  in_t  vi [NV];
  exp_t ve [NV];
  in_t  t;

  initial begin
    apply('0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reset-state rename of two instructions
    vi[0] = '{0,5,2,1, 0,0,3,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[0] = '{0,1,0, 5,1, 0,1,0, 0, 32,33,2,3, 0,0, 0};
    // inst2 source forwarded from inst1 dest
    vi[1] = '{2,3,7,1, 7,2,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[1] = '{32,0,0, 33,0, 34,0,0, 32, 34,0,7,0, 0,0, 0};
    // CDB write of tag 34 while reading it
    vi[2] = '{7,0,0,0, 7,0,0,0, 1,34,64'hDEAD, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[2] = '{34,BYP,(BYP ? 64'hDEAD : 64'h0), 0,1, 34,BYP,(BYP ? 64'hDEAD : 64'h0), 0,
              0,0,0,0, 0,0, 0};
    // written value visible; retire arf 7 -> prf 34 frees prf 7
    vi[3] = '{7,0,0,0, 7,0,0,0, 0,0,0, 0,0,0, 1,7,34, 0,0,0, 0};
    ve[3] = '{34,1,64'hDEAD, 0,1, 34,1,64'hDEAD, 0, 0,0,0,0, 0,0, 64'hDEAD};
    // single rename takes freed prf 7
    vi[4] = '{7,0,9,1, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[4] = '{34,1,64'hDEAD, 0,1, 0,1,0, 0, 7,0,9,0, 0,0, 0};
    // mispredict with a pending rename request and a retire of arf 9 -> prf 7
    vi[5] = '{2,0,4,1, 9,0,0,0, 0,0,0, 0,0,0, 1,9,7, 0,0,0, 1};
    ve[5] = '{32,0,0, 0,1, 7,0,0, 0, 0,0,4,0, 0,0, 0};
    // recovered map; equal destinations, inst2 old_dest forwarded
    vi[6] = '{2,7,5,1, 9,3,5,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[6] = '{2,1,0, 34,1, 7,0,0, 3, 9,32,5,9, 0,0, 0};
    // both CDB ports write tag 32; cdb2 wins
    vi[7] = '{5,0,0,0, 5,0,0,0, 1,32,64'h111, 1,32,64'h222, 0,0,0, 0,0,0, 0};
    ve[7] = '{32,BYP,(BYP ? 64'h222 : 64'h0), 0,1, 32,BYP,(BYP ? 64'h222 : 64'h0), 0,
              0,0,0,0, 0,0, 0};
    // double retire on same arf; freed entries not allocatable this cycle
    vi[8] = '{5,0,0,0, 0,0,6,1, 0,0,0, 0,0,0, 1,5,9, 1,5,32, 0};
    ve[8] = '{32,1,64'h222, 0,1, 0,1,0, 0, 0,33,0,6, 0,0, 0};
    // entries 5 and 9 freed by retire now allocated
    vi[9] = '{0,0,10,1, 0,0,11,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
    ve[9] = '{0,1,0, 0,1, 0,1,0, 0, 5,9,10,11, 0,0, 0};

    for (int n = 0; n < NV; n++) begin
      apply(vi[n]);
      @(negedge clock);
      check_vec(n, ve[n]);
      @(posedge clock);
      #1;
    end

    // drain free list down to one entry (free: 35..63)
    t = '0;
    t.i1_dest = 5'd12; t.i1_ren = 1'b1; t.i2_dest = 5'd13; t.i2_ren = 1'b1;
    for (int k = 0; k < 14; k++) begin
      apply(t);
      @(negedge clock);
      chk($sformatf("drain%0d.dest1", k), 64'(inst1_dest_prf), 64'(35 + 2 * k));
      chk($sformatf("drain%0d.dest2", k), 64'(inst2_dest_prf), 64'(36 + 2 * k));
      chk($sformatf("drain%0d.halt", k), 64'(rename_halt), 64'(0));
      @(posedge clock);
      #1;
    end

    // two requests, one free entry
    apply(t);
    @(negedge clock);
    chk("halt2.halt", 64'(rename_halt), 64'(1));
    chk("halt2.dest1", 64'(inst1_dest_prf), 64'(0));
    chk("halt2.dest2", 64'(inst2_dest_prf), 64'(0));
    chk("halt2.full", 64'(prf_is_full), 64'(0));
    chk("halt2.old1", 64'(inst1_old_dest_prf), 64'(61));
    chk("halt2.old2", 64'(inst2_old_dest_prf), 64'(62));
    @(posedge clock);
    #1;

    // RAT untouched by halted cycle; single request takes last entry
    t = '0;
    t.i1_opa = 5'd12; t.i1_dest = 5'd14; t.i1_ren = 1'b1;
    apply(t);
    @(negedge clock);
    chk("single.opa1_prf", 64'(inst1_opa_prf), 64'(61));
    chk("single.dest1", 64'(inst1_dest_prf), 64'(63));
    chk("single.halt", 64'(rename_halt), 64'(0));
    @(posedge clock);
    #1;

    t = '0;
    t.i1_opa = 5'd14; t.i1_dest = 5'd15; t.i1_ren = 1'b1;
    apply(t);
    @(negedge clock);
    chk("full.full", 64'(prf_is_full), 64'(1));
    chk("full.halt", 64'(rename_halt), 64'(1));
    chk("full.dest1", 64'(inst1_dest_prf), 64'(0));
    chk("full.opa1_prf", 64'(inst1_opa_prf), 64'(63));
    chk("full.opa1_rdy", 64'(inst1_opa_ready), 64'(0));
    @(posedge clock);
    #1;

    // mispredict while full: no halt, nothing allocated
    t.misp = 1'b1;
    apply(t);
    @(negedge clock);
    chk("mispfull.halt", 64'(rename_halt), 64'(0));
    chk("mispfull.dest1", 64'(inst1_dest_prf), 64'(0));
    @(posedge clock);
    #1;

    // free list rebuilt from RRAT {5->32, 7->34, 9->7}: lowest free is 5
    t = '0;
    t.i1_opa = 5'd12; t.i1_opb = 5'd5; t.i1_dest = 5'd1; t.i1_ren = 1'b1;
    apply(t);
    @(negedge clock);
    chk("recov.opa1_prf", 64'(inst1_opa_prf), 64'(12));
    chk("recov.opa1_rdy", 64'(inst1_opa_ready), 64'(1));
    chk("recov.opb1_prf", 64'(inst1_opb_prf), 64'(32));
    chk("recov.opb1_val", inst1_opb_value, 64'h222);
    chk("recov.full", 64'(prf_is_full), 64'(0));
    chk("recov.dest1", 64'(inst1_dest_prf), 64'(5));
    @(posedge clock);
    #1;

    // reset mid-operation restores reset state in one cycle
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    t = '0;
    t.i1_opa = 5'd12; t.i1_opb = 5'd7; t.i1_dest = 5'd1; t.i1_ren = 1'b1;
    apply(t);
    @(negedge clock);
    chk("rst.opa1_prf", 64'(inst1_opa_prf), 64'(12));
    chk("rst.opa1_rdy", 64'(inst1_opa_ready), 64'(1));
    chk("rst.opb1_prf", 64'(inst1_opb_prf), 64'(7));
    chk("rst.dest1", 64'(inst1_dest_prf), 64'(32));
    chk("rst.full", 64'(prf_is_full), 64'(0));
    @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
